pipeline_control: RTL

//   Sequences the 3-stage RV32 pipeline (fetch/decode -> execute -> writeback) around the Execute stage.

---
 rtl/pipeline_control.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipeline_control.sv
// Pipeline sequencer for the 3-stage RV32 core (fetch/decode -> execute -> writeback).
// Owns the fetch PC, stage enables/bubbles/holds, hazard resolution and the
// cycle/instret counters exported to the CSR file.
module pipeline_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_2000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_we,
   input  logic             ex_jump,
   input  logic [31:0]      ex_target,
   input  logic             mem_stall,
   input  logic             wb_valid,
   output logic [31:0]      pc,
   output logic             if_id_we,
   output logic             id_bubble,
   output logic             ex_hold,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_d;
   logic        kill_q, kill_d;
   logic        load_use;

   // Load in execute whose result the decode instruction needs next cycle.
   always_comb begin
      load_use = ex_valid & ex_is_load & ex_reg_we & (ex_rd != 5'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd)));
   end

   // Next-state, next-PC and stage control outputs.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      kill_d    = kill_q;
      if_id_we  = 1'b0;
      id_bubble = 1'b0;
      ex_hold   = 1'b0;
      if (rst) begin
         id_bubble = 1'b1;
      end else begin
         unique case (state_q)
            BOOT: begin
               if_id_we  = 1'b1;
               id_bubble = 1'b1;
               state_d   = RUN;
            end
            // MEM_WAIT shares RUN's decision tree: once the stall drops the
            // RUN rules apply in the same cycle, so one path serves both.
            RUN, MEM_WAIT: begin
               if (mem_stall) begin
                  ex_hold = 1'b1;
                  state_d = MEM_WAIT;
               end else begin
                  state_d = RUN;
                  if (ex_valid && ex_jump) begin
                     pc_d      = ex_target & 32'hFFFF_FFFC;
                     kill_d    = 1'b1;
                     if_id_we  = 1'b1;
                     id_bubble = 1'b1;
                  end else if (load_use) begin
                     id_bubble = 1'b1;
                  end else begin
                     pc_d      = pc + 32'd4;
                     kill_d    = 1'b0;
                     if_id_we  = 1'b1;
                     id_bubble = kill_q;
                  end
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   // State, PC and wrong-path flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc      <= RESET_PC;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         kill_q  <= kill_d;
      end
   end

   // Cycle and retired-instruction counters, wrapping at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (wb_valid && !ex_hold) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
         end
      end
   end

endmodule
